// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: drains buart's holding register into a DEPTH-entry FIFO polled by the CPU.
// Drop-newest on overflow; a pop on the same edge frees room for a push into a full FIFO.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_button,
  input  logic          uart_valid,
  input  logic [7:0]    uart_data,
  output logic          uart_rd,
  input  logic          cpu_rd,
  output logic [7:0]    cpu_data,
  output logic          not_empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          clear_overflow
);
  typedef enum logic [1:0] {IDLE = 2'b00, ACK = 2'b01, GAP = 2'b10} state_t;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  state_t state, state_next;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic capture, pop, push, discard;
  always_comb begin
    state_next = IDLE;
    uart_rd = 1'b0;
    if (state == IDLE && uart_valid) state_next = ACK;
    if (state == ACK) begin
      state_next = GAP;
      uart_rd = 1'b1;
    end
  end
  assign capture = state == IDLE && uart_valid;
  assign not_empty = level != '0;
  assign full = level == FULL_LVL;
  assign pop = cpu_rd && not_empty;
  assign push = capture && (!full || pop);
  assign discard = capture && !push;
  always_ff @(posedge clk or negedge reset_button)
    if (!reset_button) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      cpu_data <= 8'h00;
      level <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      cpu_data <= pop ? mem[rd_ptr] : cpu_rd ? 8'h00 : cpu_data;
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= discard ? 1'b1 : clear_overflow ? 1'b0 : overflow;
    end
  end
  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= uart_data;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random traffic checked against a queue model of the FIFO.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  logic clk = 1'b0;
  logic reset_button = 1'b0;
  logic uart_valid = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic uart_rd;
  logic cpu_rd = 1'b0;
  logic [7:0] cpu_data;
  logic not_empty, full, overflow;
  logic [AW:0] level;
  logic clear_overflow = 1'b0;
  int n_checks = 0;
  int n_fails = 0;
  logic [7:0] mq[$];
  logic m_ovf = 1'b0;
  logic [7:0] exp_data = 8'h00;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_button(reset_button), .uart_valid(uart_valid), .uart_data(uart_data),
    .uart_rd(uart_rd), .cpu_rd(cpu_rd), .cpu_data(cpu_data), .not_empty(not_empty),
    .full(full), .level(level), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".level"}, 32'(level), 32'(mq.size()));
    check({tag, ".not_empty"}, 32'(not_empty), 32'(mq.size() != 0));
    check({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One transaction starting at a negedge with the drain FSM idle.
  task automatic xfer(input bit ps, input logic [7:0] b, input bit pp, input bit clr);
    bit disc;
    uart_valid = ps;
    uart_data = b;
    cpu_rd = pp;
    clear_overflow = clr;
    @(negedge clk);
    if (pp) exp_data = mq.size() > 0 ? mq.pop_front() : 8'h00;
    disc = ps && mq.size() >= DEPTH;
    if (ps && !disc) mq.push_back(b);
    if (clr) m_ovf = 1'b0;
    if (disc) m_ovf = 1'b1;
    uart_valid = 1'b0;
    cpu_rd = 1'b0;
    clear_overflow = 1'b0;
    check("ack", 32'(uart_rd), 32'(ps));
    check("cpu_data", 32'(cpu_data), 32'(exp_data));
    check_status("xfer");
    if (ps) begin
      @(negedge clk);
      check("gap", 32'(uart_rd), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    bit ps, pp;
    int pushed, sz, r;
    repeat (2) @(negedge clk);
    check("rst.uart_rd", 32'(uart_rd), 0);
    check("rst.cpu_data", 32'(cpu_data), 0);
    check_status("rst");
    reset_button = 1'b1;
    @(negedge clk);

    xfer(1, 8'h41, 0, 0);
    xfer(1, 8'h42, 0, 0);
    xfer(1, 8'h43, 0, 0);
    check("three.level", 32'(level), 3);
    repeat (3) xfer(0, 8'h00, 1, 0);
    check("three.last", 32'(cpu_data), 32'h43);
    xfer(0, 8'h00, 1, 0);
    check("empty.cpu_data", 32'(cpu_data), 0);

    for (int i = 0; i < 16; i++) xfer(1, 8'(i), 0, 0);
    xfer(1, 8'hAA, 0, 0);
    check("ovf.flag", 32'(overflow), 1);
    check("ovf.level", 32'(level), 16);
    repeat (16) xfer(0, 8'h00, 1, 0);
    xfer(0, 8'h00, 0, 1);
    check("ovf.clear", 32'(overflow), 0);

    for (int i = 0; i < 16; i++) xfer(1, 8'(8'h80 + i), 0, 0);
    xfer(1, 8'h55, 1, 0);
    check("fullpp.head", 32'(cpu_data), 32'h80);
    check("fullpp.level", 32'(level), 16);
    check("fullpp.ovf", 32'(overflow), 0);
    repeat (16) xfer(0, 8'h00, 1, 0);
    check("fullpp.tail", 32'(cpu_data), 32'h55);

    pushed = 0;
    while (pushed < 40) begin
      sz = mq.size();
      r = int'($urandom_range(0, 2));
      ps = sz < 1 ? 1'b1 : sz >= 5 ? 1'b0 : (r != 1);
      pp = sz >= 5 ? 1'b1 : sz < 1 ? 1'b0 : (r != 0);
      xfer(ps, 8'($urandom), pp, 0);
      if (ps) pushed++;
    end
    while (mq.size() > 0) xfer(0, 8'h00, 1, 0);
    check("wrap.ovf", 32'(overflow), 0);

    for (int i = 0; i < 150; i++)
      xfer(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    for (int i = 0; i < 100; i++)
      xfer($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
    while (mq.size() > 0) xfer(0, 8'h00, 1, 0);
    xfer(0, 8'h00, 0, 1);

    xfer(1, 8'h11, 0, 0);
    xfer(1, 8'h22, 0, 0);
    xfer(1, 8'h33, 0, 0);
    xfer(0, 8'h00, 1, 0);
    check("pre.level", 32'(level), 2);
    uart_valid = 1'b1;
    uart_data = 8'h44;
    @(negedge clk);
    check("pre.ack", 32'(uart_rd), 1);
    #2 reset_button = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    exp_data = 8'h00;
    check("arst.uart_rd", 32'(uart_rd), 0);
    check("arst.cpu_data", 32'(cpu_data), 0);
    check_status("arst");
    @(negedge clk);
    reset_button = 1'b1;
    @(negedge clk);
    check("refetch.ack", 32'(uart_rd), 1);
    uart_valid = 1'b0;
    mq.push_back(8'h44);
    @(negedge clk);
    check("refetch.gap", 32'(uart_rd), 0);
    @(negedge clk);
    check_status("refetch");
    xfer(0, 8'h00, 1, 0);
    check("refetch.data", 32'(cpu_data), 32'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
